// File: rtl/monobit_freq_test.sv
// Monobit frequency test with per-sub-block frequency check.
// Accumulates N = 2^LOG2_N bits as a +1/-1 running sum, checks every
// M = 2^LOG2_M bit sub-block for excessive ones/zeros imbalance and
// publishes one registered verdict per complete sequence.
module monobit_freq_test #(
   parameter int LOG2_N = 7,
   parameter int LOG2_M = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       bit_in,
   input  logic                       bit_vld,
   output logic                       bit_rdy,
   input  logic [LOG2_N:0]            mono_thr,
   input  logic [LOG2_M-1:0]          blk_thr,
   output logic                       res_vld,
   output logic signed [LOG2_N+1:0]   sum,
   output logic                       mono_pass,
   output logic                       blk_pass,
   output logic                       is_random,
   output logic [LOG2_N-LOG2_M:0]     blk_fail_cnt,
   output logic [15:0]                seq_cnt,
   output logic [15:0]                fail_cnt
);

   localparam int SW = LOG2_N + 2;          // running sum width (signed)
   localparam int BW = LOG2_N;              // bit position within sequence
   localparam int OW = LOG2_M + 1;          // ones count within a sub-block
   localparam int FW = LOG2_N - LOG2_M + 1; // failing sub-block count

   localparam logic [OW-1:0] HALF_M = OW'(1) << (LOG2_M - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Reset-release qualifier: the first edge after rst deasserts only arms
   // the block, so IDLE->ACCUM happens on the second edge.
   logic armed;

   // Accumulation state
   logic signed [SW-1:0] run_sum;
   logic [BW-1:0]        bit_cnt;
   logic [OW-1:0]        ones;
   logic [FW-1:0]        fails;

   // Per-transfer next values and verdicts
   logic                 accept;
   logic                 last_bit;
   logic                 blk_end;
   logic signed [SW-1:0] step;
   logic signed [SW-1:0] sum_nxt;
   logic [OW-1:0]        ones_nxt;
   logic [OW-1:0]        dev;
   logic                 blk_bad;
   logic [FW-1:0]        fails_nxt;
   logic [SW-1:0]        mag;
   logic                 mono_ok;
   logic                 blk_ok;

   // Arm the FSM one edge after reset release.
   // NOTE: sequential state is always written with non-blocking '<=' so every
   // flop samples the pre-edge values of its peers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) armed <= 1'b0;
      else      armed <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // FSM next-state logic; clr aborts from ACCUM or RESULT.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (armed) state_nxt = ACCUM;
         ACCUM: begin
            if (clr)                      state_nxt = IDLE;
            else if (accept && last_bit)  state_nxt = RESULT;
         end
         RESULT:  state_nxt = clr ? IDLE : ACCUM;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: handshake ready only while accumulating and not aborting.
   always_comb begin
      bit_rdy = (state == ACCUM) && !clr;
      res_vld = (state == RESULT);
   end

   // Next-value datapath for the bit being transferred this cycle.
   always_comb begin
      accept    = bit_vld && bit_rdy;
      last_bit  = &bit_cnt;
      blk_end   = &bit_cnt[LOG2_M-1:0];
      step      = bit_in ? SW'(1) : {SW{1'b1}};
      sum_nxt   = run_sum + step;
      ones_nxt  = ones + OW'(bit_in);
      dev       = (ones_nxt >= HALF_M) ? (ones_nxt - HALF_M) : (HALF_M - ones_nxt);
      blk_bad   = blk_end && (dev > OW'(blk_thr));
      fails_nxt = fails + FW'(blk_bad);
      mag       = sum_nxt[SW-1] ? SW'(-sum_nxt) : SW'(sum_nxt);
      mono_ok   = (mag <= SW'(mono_thr));
      blk_ok    = (fails_nxt == '0);
   end

   // Accumulators: cleared outside ACCUM, advanced only on a transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_sum <= '0;
         bit_cnt <= '0;
         ones    <= '0;
         fails   <= '0;
      end else if (state != ACCUM) begin
         run_sum <= '0;
         bit_cnt <= '0;
         ones    <= '0;
         fails   <= '0;
      end else if (accept) begin
         run_sum <= sum_nxt;
         bit_cnt <= bit_cnt + BW'(1);
         ones    <= blk_end ? '0 : ones_nxt;
         fails   <= fails_nxt;
      end
   end

   // Result registers: loaded on the edge that accepts the final bit and held
   // otherwise, including across an aborted sequence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum          <= '0;
         mono_pass    <= 1'b0;
         blk_pass     <= 1'b0;
         is_random    <= 1'b0;
         blk_fail_cnt <= '0;
         seq_cnt      <= '0;
         fail_cnt     <= '0;
      end else if (accept && last_bit) begin
         sum          <= sum_nxt;
         mono_pass    <= mono_ok;
         blk_pass     <= blk_ok;
         is_random    <= mono_ok && blk_ok;
         blk_fail_cnt <= fails_nxt;
         seq_cnt      <= seq_cnt + 16'd1;
         if (!(mono_ok && blk_ok) && (fail_cnt != 16'hFFFF))
            fail_cnt <= fail_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_monobit_freq_test.sv
// Self-checking bench for monobit_freq_test (LOG2_N=7, LOG2_M=4).
// Expected verdicts are computed from the stimulus and queued before each
// sequence is driven; a monitor pops and compares on every res_vld strobe.
module tb_monobit_freq_test;

   localparam int N = 128;
   localparam int M = 16;

   logic              clk;
   logic              rst;
   logic              clr;
   logic              bit_in;
   logic              bit_vld;
   logic              bit_rdy;
   logic [7:0]        mono_thr;
   logic [3:0]        blk_thr;
   logic              res_vld;
   logic signed [8:0] sum;
   logic              mono_pass;
   logic              blk_pass;
   logic              is_random;
   logic [3:0]        blk_fail_cnt;
   logic [15:0]       seq_cnt;
   logic [15:0]       fail_cnt;

   typedef struct {
      int sum;
      int blk_fail;
      bit mono_pass;
      bit blk_pass;
      bit is_random;
      int seq;
      int fail;
   } exp_t;

   exp_t sb_q[$];
   bit   stim[N];
   int   m_seq;
   int   m_fail;
   int   xfers;
   int   checks;
   int   errors;

   monobit_freq_test #(.LOG2_N(7), .LOG2_M(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .bit_in       (bit_in),
      .bit_vld      (bit_vld),
      .bit_rdy      (bit_rdy),
      .mono_thr     (mono_thr),
      .blk_thr      (blk_thr),
      .res_vld      (res_vld),
      .sum          (sum),
      .mono_pass    (mono_pass),
      .blk_pass     (blk_pass),
      .is_random    (is_random),
      .blk_fail_cnt (blk_fail_cnt),
      .seq_cnt      (seq_cnt),
      .fail_cnt     (fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: derive the verdict from stim[] and the thresholds.
   task automatic push_expected(input int n_thr, input int b_thr);
      exp_t e;
      int   s, f, ones, dev;
      s = 0;
      f = 0;
      for (int i = 0; i < N; i++) s += stim[i] ? 1 : -1;
      for (int b = 0; b < N / M; b++) begin
         ones = 0;
         for (int j = 0; j < M; j++) ones += int'(stim[b*M + j]);
         dev = (ones > M/2) ? ones - M/2 : M/2 - ones;
         if (dev > b_thr) f++;
      end
      e.sum       = s;
      e.blk_fail  = f;
      e.mono_pass = ((s < 0 ? -s : s) <= n_thr);
      e.blk_pass  = (f == 0);
      e.is_random = e.mono_pass && e.blk_pass;
      m_seq       = (m_seq + 1) % 65536;
      if (!e.is_random && m_fail < 65535) m_fail++;
      e.seq       = m_seq;
      e.fail      = m_fail;
      sb_q.push_back(e);
   endtask

   task automatic fill_alternating();
      for (int i = 0; i < N; i++) stim[i] = (i % 2 == 0);
   endtask

   // Drive stim[] until n_bits are accepted; abort_at >= 0 raises clr once
   // that many bits have been accepted. bit_vld is left as driven.
   task automatic drive_bits(input int n_bits, input int gap_pct, input int abort_at);
      int idx, budget;
      bit acc;
      idx    = 0;
      budget = 0;
      while (idx < n_bits) begin
         @(negedge clk);
         if (budget >= 4000) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: accepted %0d, wanted %0d", idx, n_bits);
            bit_vld = 1'b0;
            return;
         end
         budget++;
         if (idx == abort_at) begin
            clr     = 1'b1;
            bit_vld = 1'b1;
            bit_in  = stim[idx];
            #1;
            checks++;
            if (bit_rdy !== 1'b0) begin
               errors++;
               $display("FAIL rdy_during_clr: got %b, want 0", bit_rdy);
            end
            @(negedge clk);
            clr     = 1'b0;
            bit_vld = 1'b0;
            xfers   = 0;
            return;
         end
         bit_in  = stim[idx];
         bit_vld = ($urandom_range(0, 99) >= gap_pct);
         #1 acc  = bit_vld && bit_rdy;
         @(posedge clk);
         if (acc) begin
            idx++;
            xfers++;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst     = 1'b0;
      clr     = 1'b0;
      bit_vld = 1'b0;
      sb_q.delete();
      m_seq   = 0;
      m_fail  = 0;
      xfers   = 0;
      @(negedge clk);
      rst     = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   // Scoreboard monitor: every strobe must match the head of the queue.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && res_vld) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: seq_cnt=%0d", seq_cnt);
            end else begin
               e = sb_q.pop_front();
               checks += 8;
               if (int'(sum) !== e.sum) begin
                  errors++; $display("FAIL sum: got %0d, want %0d", sum, e.sum);
               end
               if (int'(blk_fail_cnt) !== e.blk_fail) begin
                  errors++; $display("FAIL blk_fail_cnt: got %0d, want %0d", blk_fail_cnt, e.blk_fail);
               end
               if (mono_pass !== e.mono_pass) begin
                  errors++; $display("FAIL mono_pass: got %b, want %b", mono_pass, e.mono_pass);
               end
               if (blk_pass !== e.blk_pass) begin
                  errors++; $display("FAIL blk_pass: got %b, want %b", blk_pass, e.blk_pass);
               end
               if (is_random !== e.is_random) begin
                  errors++; $display("FAIL is_random: got %b, want %b", is_random, e.is_random);
               end
               if (int'(seq_cnt) !== e.seq) begin
                  errors++; $display("FAIL seq_cnt: got %0d, want %0d", seq_cnt, e.seq);
               end
               if (int'(fail_cnt) !== e.fail) begin
                  errors++; $display("FAIL fail_cnt: got %0d, want %0d", fail_cnt, e.fail);
               end
               if (xfers !== N) begin
                  errors++; $display("FAIL strobe_spacing: got %0d transfers, want %0d", xfers, N);
               end
            end
            xfers = 0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      checks += 3;
      if ({bit_rdy, res_vld, mono_pass, blk_pass, is_random} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b, want 00000",
                            {bit_rdy, res_vld, mono_pass, blk_pass, is_random});
      end
      if (sum !== '0 || blk_fail_cnt !== '0) begin
         errors++; $display("FAIL reset_sum: got sum=%0d blk=%0d, want 0 0", sum, blk_fail_cnt);
      end
      if (seq_cnt !== '0 || fail_cnt !== '0) begin
         errors++; $display("FAIL reset_cnts: got %0d %0d, want 0 0", seq_cnt, fail_cnt);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bit_rdy !== 1'b0) begin
         errors++; $display("FAIL rdy_first_edge: got %b, want 0", bit_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (bit_rdy !== 1'b1) begin
         errors++; $display("FAIL rdy_second_edge: got %b, want 1", bit_rdy);
      end
   endtask

   task automatic run_sequence(input int n_thr, input int b_thr, input int gap_pct, input string tag);
      mono_thr = 8'(n_thr);
      blk_thr  = 4'(b_thr);
      push_expected(n_thr, b_thr);
      drive_bits(N, gap_pct, -1);
      @(negedge clk);
      checks += 2;
      if (res_vld !== 1'b1) begin
         errors++; $display("FAIL %s_strobe_latency: got %b, want 1", tag, res_vld);
      end
      if (bit_rdy !== 1'b0) begin
         errors++; $display("FAIL %s_rdy_in_result: got %b, want 0", tag, bit_rdy);
      end
   endtask

   task automatic test_alternating();
      fill_alternating();
      run_sequence(28, 4, 0, "alt");
      bit_vld = 1'b0;
   endtask

   task automatic test_all_ones();
      for (int i = 0; i < N; i++) stim[i] = 1'b1;
      run_sequence(28, 4, 0, "ones");
      bit_vld = 1'b0;
   endtask

   task automatic test_mono_threshold();
      for (int i = 0; i < N; i++) stim[i] = (i < 78);
      run_sequence(28, 4, 0, "thr28");
      bit_vld = 1'b0;
      run_sequence(27, 4, 0, "thr27");
      bit_vld = 1'b0;
   endtask

   task automatic test_abort_gaps();
      apply_reset();
      fill_alternating();
      for (int i = 0; i < N; i++) stim[i] = ($urandom_range(0, 1) == 1);
      mono_thr = 8'd28;
      blk_thr  = 4'd4;
      drive_bits(N, 30, 50);
      repeat (3) @(negedge clk);
      checks++;
      if (seq_cnt !== 16'd0) begin
         errors++; $display("FAIL abort_seq_cnt: got %0d, want 0", seq_cnt);
      end
      fill_alternating();
      run_sequence(28, 4, 30, "after_abort");
      bit_vld = 1'b0;
   endtask

   task automatic test_back_to_back();
      fill_alternating();
      run_sequence(28, 4, 0, "b2b_first");
      run_sequence(28, 4, 0, "b2b_second");
      bit_vld = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < N; i++) stim[i] = 1'b1;
      drive_bits(40, 0, -1);
      bit_vld = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks += 3;
      if ({bit_rdy, res_vld, mono_pass, blk_pass, is_random} !== 5'b0) begin
         errors++; $display("FAIL async_flags: got %b, want 00000",
                            {bit_rdy, res_vld, mono_pass, blk_pass, is_random});
      end
      if (sum !== '0 || blk_fail_cnt !== '0) begin
         errors++; $display("FAIL async_sum: got sum=%0d blk=%0d, want 0 0", sum, blk_fail_cnt);
      end
      if (seq_cnt !== '0 || fail_cnt !== '0) begin
         errors++; $display("FAIL async_cnts: got %0d %0d, want 0 0", seq_cnt, fail_cnt);
      end
      sb_q.delete();
      m_seq  = 0;
      m_fail = 0;
      xfers  = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bit_rdy !== 1'b0) begin
         errors++; $display("FAIL async_rdy_first_edge: got %b, want 0", bit_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (bit_rdy !== 1'b1) begin
         errors++; $display("FAIL async_rdy_second_edge: got %b, want 1", bit_rdy);
      end
      fill_alternating();
      run_sequence(28, 4, 10, "post_reset");
      bit_vld = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      m_seq    = 0;
      m_fail   = 0;
      xfers    = 0;
      clr      = 1'b0;
      bit_in   = 1'b0;
      bit_vld  = 1'b0;
      mono_thr = 8'd28;
      blk_thr  = 4'd4;
      fork
         monitor();
      join_none
      test_reset();
      test_alternating();
      test_all_ones();
      test_mono_threshold();
      test_abort_gaps();
      test_back_to_back();
      test_async_reset();
      repeat (4) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL missing_strobes: %0d results never produced", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
